// File: rtl/wishbone_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter_pkg
// Shared definitions for the N-master Wishbone arbiter:
//   - arb_state_t  : arbiter FSM encodings (ST_ABORT present only when the
//                    ack watchdog is compiled in via WB_ARB_TIMEOUT_EN)
//   - TIMEOUT_DATA : read data returned to a master whose cycle was aborted
//   - clog2()      : ceiling log2 for sizing index/counter fields
// Optional feature macro: WB_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package wishbone_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
    ,
    ST_ABORT = 2'd2
`endif
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational rotating-priority picker. Searches the request vector upward
// from (i_last + 1) mod N, wrapping around, and returns the first requester
// found as a one-hot vector (all zero when nothing is requesting).
// Ports:
//   i_req   in  N      request vector, bit k = master k
//   i_last  in  IDX_W  index of the most recently granted master
//   o_pick  out N      one-hot winner
// -----------------------------------------------------------------------------
module rr_priority_picker
  import wishbone_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_pick
);

  localparam int             SW  = IDX_W + 1;
  localparam logic [IDX_W:0] N_L = SW'(N);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    // Offset 1..N visits every master once, ending on i_last itself, so a
    // lone requester that was just served can still be picked again.
    for (int off = 1; off <= N; off++) begin
      w_sum = {1'b0, i_last} + SW'(off);
      if (w_sum >= N_L) w_sum = w_sum - N_L;
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter_nm.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter_nm
// Round-robin arbiter connecting NUM_MASTERS Wishbone masters to one slave.
// A grant is registered one edge after a request, held for the whole master
// cycle (bursts are never split) and released with one idle cycle before the
// next arbitration. Optional ack watchdog under macro WB_ARB_TIMEOUT_EN: a
// stalled strobe is aborted after TIMEOUT_CYCLES with a fake ack carrying
// TIMEOUT_DATA and a one-cycle o_timeout pulse.
// Ports (index k = master k, packed LSB-first):
//   clk, rst                  clock, synchronous active-high reset
//   i_m_we/stb/cyc [N]        master write enable, strobe, cycle
//   i_m_sel [4N], i_m_dat, i_m_adr   master byte select, write data, address
//   o_m_dat, o_m_ack, o_m_int master read data, ack, interrupt
//   o_s_we/stb/cyc/sel/dat/adr  slave-side request mirrored from the grantee
//   i_s_dat, i_s_ack, i_s_int slave response
//   o_grant [N]               one-hot current grant, zero when idle
//   o_timeout                 one-cycle watchdog pulse (0 without the macro)
// -----------------------------------------------------------------------------
module wishbone_arbiter_nm
  import wishbone_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_MASTERS-1:0]             i_m_we,
  input  logic [NUM_MASTERS-1:0]             i_m_stb,
  input  logic [NUM_MASTERS-1:0]             i_m_cyc,
  input  logic [4*NUM_MASTERS-1:0]           i_m_sel,
  input  logic [DATA_WIDTH*NUM_MASTERS-1:0]  i_m_dat,
  input  logic [ADDR_WIDTH*NUM_MASTERS-1:0]  i_m_adr,
  output logic [DATA_WIDTH*NUM_MASTERS-1:0]  o_m_dat,
  output logic [NUM_MASTERS-1:0]             o_m_ack,
  output logic [NUM_MASTERS-1:0]             o_m_int,
  output logic                               o_s_we,
  output logic                               o_s_stb,
  output logic                               o_s_cyc,
  output logic [3:0]                         o_s_sel,
  output logic [DATA_WIDTH-1:0]              o_s_dat,
  output logic [ADDR_WIDTH-1:0]              o_s_adr,
  input  logic [DATA_WIDTH-1:0]              i_s_dat,
  input  logic                               i_s_ack,
  input  logic                               i_s_int,
  output logic [NUM_MASTERS-1:0]             o_grant,
  output logic                               o_timeout
);

  localparam int                    IDX_W       = clog2(NUM_MASTERS);
  localparam logic [DATA_WIDTH-1:0] W_ABORT_DAT = DATA_WIDTH'(TIMEOUT_DATA);

  arb_state_t             r_state, w_state_next;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_next;
  logic [IDX_W-1:0]       r_gidx, w_gidx_next;
  logic [IDX_W-1:0]       r_last, w_last_next;
  logic [NUM_MASTERS-1:0] w_pick;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_busy;
  logic                   w_abort;
  logic                   w_cyc_granted;

  logic [3:0]            w_m_sel [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] w_m_dat [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] w_m_adr [NUM_MASTERS];

  rr_priority_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req  (i_m_cyc),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (w_pick[k]) w_pick_idx = IDX_W'(k);
    end
  end

  assign w_busy        = (r_state == ST_BUSY);
  assign w_cyc_granted = i_m_cyc[r_gidx];
  assign o_grant       = r_grant;

  // Per-master unpacking and return path. r_grant is one-hot, so only the
  // grantee can ever see a non-zero response. Ack is masked while rst is high
  // so a reset landing mid-burst never completes a beat.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign w_m_sel[gi] = i_m_sel[gi*4 +: 4];
      assign w_m_dat[gi] = i_m_dat[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_m_adr[gi] = i_m_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      assign o_m_ack[gi] = r_grant[gi] & ~rst & ((w_busy & i_s_ack) | w_abort);
      assign o_m_int[gi] = r_grant[gi] & w_busy & i_s_int;
      assign o_m_dat[gi*DATA_WIDTH +: DATA_WIDTH] =
          !r_grant[gi] ? '0 :
          w_abort      ? W_ABORT_DAT :
          w_busy       ? i_s_dat : '0;
    end
  endgenerate

  // Slave side mirrors the grantee only in BUSY; ABORT and IDLE drive zeros.
  assign o_s_cyc = w_busy & i_m_cyc[r_gidx];
  assign o_s_stb = w_busy & i_m_stb[r_gidx];
  assign o_s_we  = w_busy & i_m_we[r_gidx];
  assign o_s_sel = w_busy ? w_m_sel[r_gidx] : 4'h0;
  assign o_s_dat = w_busy ? w_m_dat[r_gidx] : '0;
  assign o_s_adr = w_busy ? w_m_adr[r_gidx] : '0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int               CNT_W     = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wdog_cnt;
  logic             r_timeout;
  logic             w_wdog_hit;

  assign w_abort = (r_state == ST_ABORT);
  // Firing on the TIMEOUT_CYCLES-th stalled cycle lands ABORT exactly
  // TIMEOUT_CYCLES cycles after the strobe first appeared.
  assign w_wdog_hit = o_s_stb & ~i_s_ack & (r_wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wdog_cnt <= (o_s_stb & ~i_s_ack) ? r_wdog_cnt + 1'b1 : '0;
      r_timeout  <= (r_state == ST_BUSY) && (w_state_next == ST_ABORT);
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused;
  assign w_unused  = (TIMEOUT_CYCLES != 0);
  assign w_abort   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_gidx_next  = r_gidx;
    w_last_next  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|i_m_cyc) begin
          w_state_next = ST_BUSY;
          w_grant_next = w_pick;
          w_gidx_next  = w_pick_idx;
        end
      end
      ST_BUSY: begin
        if (!w_cyc_granted) begin
          w_state_next = ST_IDLE;
          w_grant_next = '0;
          w_last_next  = r_gidx;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (w_wdog_hit) begin
          w_state_next = ST_ABORT;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (w_cyc_granted) begin
          w_state_next = ST_BUSY;
        end else begin
          w_state_next = ST_IDLE;
          w_grant_next = '0;
          w_last_next  = r_gidx;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_gidx  <= w_gidx_next;
      r_last  <= w_last_next;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_nm.sv
// -----------------------------------------------------------------------------
// tb_wishbone_arbiter_nm
// Directed scenarios for the 4-master arbiter with a simple always-ready
// slave model (read data = address ^ 32'hC0DE0000). Expected grants and acks
// are queued when each request is issued; a negedge monitor pops and compares
// them whenever the DUT presents a new grant or an ack.
// -----------------------------------------------------------------------------
module tb_wishbone_arbiter_nm;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      m_we  = '0;
  logic [N-1:0]      m_stb = '0;
  logic [N-1:0]      m_cyc = '0;
  logic [4*N-1:0]    m_sel = '0;
  logic [DW*N-1:0]   m_dat = '0;
  logic [AW*N-1:0]   m_adr = '0;
  logic [DW*N-1:0]   o_m_dat;
  logic [N-1:0]      o_m_ack;
  logic [N-1:0]      o_m_int;
  logic              o_s_we, o_s_stb, o_s_cyc;
  logic [3:0]        o_s_sel;
  logic [DW-1:0]     o_s_dat;
  logic [AW-1:0]     o_s_adr;
  logic [DW-1:0]     s_dat;
  logic              s_ack;
  logic              s_int = 1'b1;
  logic              s_ack_en = 1'b1;
  logic              s_ack_force = 1'b0;
  logic [N-1:0]      o_grant;
  logic              o_timeout;

  always #5 clk = ~clk;

  wishbone_arbiter_nm #(
    .NUM_MASTERS    (N),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_m_we    (m_we),
    .i_m_stb   (m_stb),
    .i_m_cyc   (m_cyc),
    .i_m_sel   (m_sel),
    .i_m_dat   (m_dat),
    .i_m_adr   (m_adr),
    .o_m_dat   (o_m_dat),
    .o_m_ack   (o_m_ack),
    .o_m_int   (o_m_int),
    .o_s_we    (o_s_we),
    .o_s_stb   (o_s_stb),
    .o_s_cyc   (o_s_cyc),
    .o_s_sel   (o_s_sel),
    .o_s_dat   (o_s_dat),
    .o_s_adr   (o_s_adr),
    .i_s_dat   (s_dat),
    .i_s_ack   (s_ack),
    .i_s_int   (s_int),
    .o_grant   (o_grant),
    .o_timeout (o_timeout)
  );

  // Slave model
  assign s_ack = (o_s_stb & s_ack_en) | s_ack_force;
  assign s_dat = o_s_adr ^ 32'hC0DE0000;

  function automatic logic [31:0] slave_rd(input logic [31:0] adr);
    return adr ^ 32'hC0DE0000;
  endfunction

  typedef struct {
    int          m;
    logic [31:0] d;
  } exp_t;

  exp_t ack_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beats[N];
  logic [N-1:0] ack_seen = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [N-1:0] prev_grant = '0;
  bit           had_grant  = 1'b0;
  int           idle_run   = 0;

  always @(negedge clk) begin
    exp_t e;
    int   g;
    ack_seen = o_m_ack;
    if (rst) begin
      check("ack_in_reset", o_m_ack, 0);
      had_grant  = 1'b0;
      prev_grant = '0;
      idle_run   = 0;
    end else begin
      check("grant_onehot", $onehot0(o_grant), 1);
      if (o_grant == '0) begin
        idle_run++;
        check("idle_outputs", |{o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_adr, o_s_dat,
                                o_m_ack, o_m_int, o_m_dat}, 0);
      end else if (o_grant != prev_grant) begin
        if (grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got %b expected none", o_grant);
        end else begin
          g = grant_q.pop_front();
          check("grant_order", o_grant, 64'(1) << g);
        end
        if (had_grant) check("idle_gap", idle_run, 1);
        had_grant = 1'b1;
        idle_run  = 0;
      end
      prev_grant = o_grant;
      if (o_m_ack != '0) begin
        if (ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got %b expected none", o_m_ack);
        end else begin
          e = ack_q.pop_front();
          check("ack_target", o_m_ack, 64'(1) << e.m);
          check("ack_data", o_m_dat[e.m*DW +: DW], e.d);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (beats[k] > 0 && ack_seen[k]) begin
        beats[k]--;
        if (beats[k] == 0) begin
          m_cyc[k] = 1'b0;
          m_stb[k] = 1'b0;
          m_we[k]  = 1'b0;
        end else begin
          m_adr[k*AW +: AW] = m_adr[k*AW +: AW] + 32'd4;
        end
      end
    end
  endtask

  task automatic issue(input int k, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input int nbeats);
    exp_t e;
    m_we[k]           = we;
    m_stb[k]          = 1'b1;
    m_cyc[k]          = 1'b1;
    m_sel[k*4 +: 4]   = 4'hF;
    m_adr[k*AW +: AW] = adr;
    m_dat[k*DW +: DW] = dat;
    beats[k]          = nbeats;
    if (s_ack_en) begin
      for (int i = 0; i < nbeats; i++) begin
        e.m = k;
        e.d = slave_rd(adr + 32'(4 * i));
        ack_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((m_cyc != '0 || o_grant != '0) && n < max_cycles) begin
      step();
      n++;
    end
    check("wait_idle_bound", (m_cyc != '0 || o_grant != '0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit rearmed, wait0;
    int viol, to_cnt, to_first;
    exp_t e;
    for (int k = 0; k < N; k++) beats[k] = 0;

    // ---- Single write from master 2, plus stray slave ack while idle
    do_reset();
    s_ack_force = 1'b1;
    step();
    step();
    s_ack_force = 1'b0;
    grant_q.push_back(2);
    issue(2, 1'b1, 32'h10, 32'hA5A5A5A5, 1);
    @(negedge clk);
    check("grant_not_same_cycle", o_grant, 4'b0000);
    check("s_cyc_not_same_cycle", o_s_cyc, 0);
    step();
    @(negedge clk);
    check("single_grant", o_grant, 4'b0100);
    check("single_s_adr", o_s_adr, 32'h10);
    check("single_s_dat", o_s_dat, 32'hA5A5A5A5);
    check("single_s_we", {o_s_we, o_s_cyc, o_s_stb, o_s_sel}, 7'b111_1111);
    check("single_m_ack", o_m_ack, 4'b0100);
    check("single_m_int", o_m_int, 4'b0100);
    wait_idle(20);

    // ---- All four requesting from reset, one beat each, master 0 returns
    rst = 1'b1;
    for (int k = 0; k < N; k++) issue(k, 1'b0, 32'(32'h100 * k), 32'h0, 1);
    grant_q.push_back(0); grant_q.push_back(1);
    grant_q.push_back(2); grant_q.push_back(3);
    grant_q.push_back(0);
    step();
    step();
    rst = 1'b0;
    rearmed = 1'b0;
    wait0   = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (!rearmed && m_cyc[0] == 1'b0) begin
        if (wait0) begin
          issue(0, 1'b0, 32'h400, 32'h0, 1);
          rearmed = 1'b1;
        end else begin
          wait0 = 1'b1;
        end
      end
      if (rearmed && m_cyc == '0 && o_grant == '0) break;
    end
    check("rr_complete", (rearmed && m_cyc == '0 && o_grant == '0), 1);

    // ---- 8-beat burst from master 1 while master 3 waits
    do_reset();
    grant_q.push_back(1);
    grant_q.push_back(3);
    issue(1, 1'b0, 32'h200, 32'h0, 8);
    step();
    issue(3, 1'b0, 32'h300, 32'h0, 1);
    viol = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (o_grant[3] && m_cyc[1]) viol++;
      if (m_cyc == '0 && o_grant == '0) break;
    end
    check("burst_not_split", viol, 0);
    check("burst_complete", (m_cyc == '0 && o_grant == '0), 1);

    // ---- Reset on beat 3 of a master-0 burst, master 1 also waiting
    do_reset();
    grant_q.push_back(0);
    grant_q.push_back(0);
    grant_q.push_back(1);
    issue(0, 1'b0, 32'h500, 32'h0, 4);
    issue(1, 1'b0, 32'h700, 32'h0, 1);
    step();
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("reset_beat3_no_ack", o_m_ack, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_s_cyc", {o_s_cyc, o_s_stb}, 2'b00);
    check("reset_grant", o_grant, 4'b0000);
    step();
    @(negedge clk);
    check("reset_first_grant", o_grant, 4'b0001);
    wait_idle(30);

    // ---- Slave never acks
    do_reset();
    s_ack_en = 1'b0;
    grant_q.push_back(2);
`ifdef WB_ARB_TIMEOUT_EN
    e.m = 2;
    e.d = 32'hDEADBEEF;
    ack_q.push_back(e);
`endif
    issue(2, 1'b0, 32'h600, 32'h0, 1);
    step();
    to_cnt   = 0;
    to_first = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (o_timeout) begin
        to_cnt++;
        if (to_first < 0) to_first = i;
      end
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("timeout_pulses", to_cnt, 1);
    check("timeout_cycle", to_first, 16);
`else
    check("no_timeout", to_cnt, 0);
    check("hang_stb", o_s_stb, 1);
    check("hang_grant", o_grant, 4'b0100);
    m_cyc[2] = 1'b0;
    m_stb[2] = 1'b0;
    beats[2] = 0;
`endif
    s_ack_en = 1'b1;
    wait_idle(10);

    step();
    step();
    check("ack_queue_empty", ack_q.size(), 0);
    check("grant_queue_empty", grant_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter_nm.md
WISHBONE_ARBITER_NM -- requirements
Module: wishbone_arbiter_nm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 Parameter NUM_MASTERS SHALL default to 4 (legal range 2..16) and set the number of Wishbone master ports.
REQ-003 Parameter DATA_WIDTH SHALL default to 32 and set the data bus width.
REQ-004 Parameter ADDR_WIDTH SHALL default to 32 and set the address bus width.
REQ-005 Parameter TIMEOUT_CYCLES SHALL default to 256 and set the ack watchdog limit (used only with REQ-025).
REQ-006 Ports SHALL be as follows (index k = master k, packed LSB-first):
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- i_m_we, i_m_stb, i_m_cyc  in  NUM_MASTERS  per-master write enable, strobe, cycle
- i_m_sel  in  4*NUM_MASTERS  per-master byte select
- i_m_dat  in  DATA_WIDTH*NUM_MASTERS  per-master write data
- i_m_adr  in  ADDR_WIDTH*NUM_MASTERS  per-master address
- o_m_dat  out  DATA_WIDTH*NUM_MASTERS  per-master read data
- o_m_ack, o_m_int  out  NUM_MASTERS  per-master ack and interrupt
- o_s_we, o_s_stb, o_s_cyc  out  1  slave-side write enable, strobe, cycle
- o_s_sel  out  4  slave-side byte select
- o_s_dat  out  DATA_WIDTH  slave-side write data
- o_s_adr  out  ADDR_WIDTH  slave-side address
- i_s_dat  in  DATA_WIDTH  slave read data
- i_s_ack, i_s_int  in  1  slave ack and interrupt
- o_grant  out  NUM_MASTERS  one-hot current grant (all zero when idle)
- o_timeout  out  1  one-cycle watchdog pulse

Function
REQ-007 The FSM SHALL have states IDLE, BUSY and ABORT; ABORT SHALL exist only when REQ-025 is compiled in.
REQ-008 In IDLE with any i_m_cyc set, the next edge SHALL grant the first requesting master found by searching upward, with wrap-around, from (last_grant+1) mod NUM_MASTERS, and SHALL enter BUSY.
REQ-009 Grant SHALL be registered: slave-side cyc/stb SHALL rise no earlier than one cycle after master cyc rises.
REQ-010 In BUSY, o_s_we/stb/cyc/sel/dat/adr SHALL combinationally mirror the granted master's inputs.
REQ-011 In BUSY, the granted master SHALL receive i_s_ack, i_s_dat and i_s_int combinationally; non-granted masters SHALL see ack=0, dat=0, int=0.
REQ-012 Grant SHALL be held while the granted master's i_m_cyc is high, regardless of other requests; multi-beat bursts SHALL never be split.
REQ-013 When the granted master drops i_m_cyc, the next edge SHALL return the FSM to IDLE, clear o_grant and record last_grant; re-arbitration SHALL take place on the following edge, giving exactly one idle cycle between grants.
REQ-014 Simultaneous requests SHALL be resolved only by the rotating priority of REQ-008; a master that requests continuously SHALL be granted within NUM_MASTERS arbitration rounds.
REQ-015 In IDLE, all slave-side outputs and all o_m_ack SHALL be 0.
REQ-016 i_s_ack arriving while the FSM is in IDLE SHALL be ignored.

Reset
REQ-017 While rst is high at an edge: state SHALL go to IDLE, o_grant to 0, o_timeout to 0, watchdog counter to 0, and last_grant to NUM_MASTERS-1, so that master 0 has first priority.
REQ-018 Reset asserted mid-burst SHALL deassert o_s_cyc/o_s_stb from the next cycle, with no ack forwarded to any master.

Configuration
REQ-019 Macro WB_ARB_TIMEOUT_EN SHALL enable the watchdog (REQ-020 to REQ-023).
REQ-020 With the macro defined, a counter SHALL increment each cycle o_s_stb is high without i_s_ack, and SHALL clear on ack or when stb is low.
REQ-021 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL enter ABORT for one cycle.
REQ-022 ABORT SHALL drive o_s_stb=0, o_s_cyc=0, o_m_ack[granted]=1 and o_m_dat[granted]=32'hDEADBEEF (zero-extended or truncated to DATA_WIDTH), and SHALL pulse o_timeout.
REQ-023 After ABORT, the FSM SHALL return to BUSY (if the granted cyc is still high) or to IDLE.
REQ-024 Without the macro, the FSM SHALL have no ABORT state, o_timeout SHALL be tied to 0, and the arbiter SHALL wait indefinitely for ack.
REQ-025 REQ-020 to REQ-023 are collectively "the watchdog feature"; they SHALL be compiled only under WB_ARB_TIMEOUT_EN.

Structure
REQ-026 Package wishbone_arbiter_pkg SHALL hold the state encodings, the TIMEOUT_DATA constant (32'hDEADBEEF) and a clog2 function.
REQ-027 The rotate-and-pick logic SHALL be implemented in one combinational sub-module, rr_priority_picker (inputs: request vector, last_grant; output: one-hot pick).

Verification (NUM_MASTERS=4)
REQ-028 Reset, then master 2 alone issues a write to 0x10 with data 0xA5A5A5A5: expect o_grant=4'b0100 one cycle after cyc, slave sees adr 0x10 and data 0xA5A5A5A5, and master 2 receives the ack.
REQ-029 Masters 0..3 all hold cyc high from reset, each releasing after one beat: expect grant order 0,1,2,3,0 with exactly one idle cycle between grants.
REQ-030 Master 1 runs an 8-beat read burst while master 3 requests: expect master 3 to receive no grant until master 1 drops cyc, and all 8 acks to reach master 1 only.
REQ-031 rst is asserted on beat 3 of a burst by master 0: expect o_s_cyc=0 on the next cycle and o_grant=0; after reset, master 0 is granted first.
REQ-032 With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the slave never acks: expect o_timeout high for one cycle 16 cycles after stb, with the master receiving ack and data 0xDEADBEEF; without the macro, the bus hangs with o_timeout=0.
